// File: rtl/tx_link_scheduler_if.sv
// Serial-bit handshake bundle between the two frame sources, the scheduler and the line encoder.
// The scheduler connects through the slave modport; the driving side uses master.
interface tx_link_scheduler_if;
  logic data_bit;
  logic data_bit_valid;
  logic data_bit_ready;
  logic ctrl_bit;
  logic ctrl_bit_valid;
  logic ctrl_bit_ready;
  logic line_bit;
  logic line_bit_valid;
  logic line_bit_ready;

  modport master (
    output data_bit, data_bit_valid, ctrl_bit, ctrl_bit_valid, line_bit_ready,
    input  data_bit_ready, ctrl_bit_ready, line_bit, line_bit_valid
  );

  modport slave (
    input  data_bit, data_bit_valid, ctrl_bit, ctrl_bit_valid, line_bit_ready,
    output data_bit_ready, ctrl_bit_ready, line_bit, line_bit_valid
  );
endinterface

// File: rtl/tx_link_scheduler.sv
// Frame-granular arbiter sharing one line transmitter between data and ctrl bit sources.
// Optional TX_LINK_IDLE_FILL_EN: drive valid idle '1' bits in IDLE/GAP and count GAP in idle handshakes.
module tx_link_scheduler #(
  parameter int FRAME_BITS     = 56,
  parameter int GAP_BITS       = 4,
  parameter int MAX_CTRL_BURST = 3
) (
  input  logic                      clk_sys,
  input  logic                      rst_n,
  tx_link_scheduler_if.slave        tx,
  output logic                      grant_ctrl,
  output logic                      frame_done,
  output logic [15:0]               frames_sent,
  output logic [7:0]                underrun_count
);

  localparam int BW = $clog2(FRAME_BITS);
  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam int SW = (MAX_CTRL_BURST > 0) ? $clog2(MAX_CTRL_BURST + 1) : 1;
  localparam logic [BW-1:0] LAST_BIT   = BW'(FRAME_BITS - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_CTRL_BURST);

  typedef enum logic [1:0] {IDLE, DATA, CTRL, GAP} state_t;

  state_t        state_q;
  logic [BW-1:0] bit_cnt_q;
  logic [GW-1:0] gap_cnt_q;
  logic [SW-1:0] streak_q;
  logic [15:0]   frames_q;
  logic [7:0]    underrun_q;
  logic          frame_done_q;
  logic          stall_q;

  logic lb, lbv, drdy, crdy;
  logic hs, in_frame, stall, gap_tick;

`ifdef TX_LINK_IDLE_FILL_EN
  // Holds idle fill off while reset is asserted and for the first cycle after.
  logic run_q;
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end
`endif

  always_comb begin
    lb   = 1'b1;
    lbv  = 1'b0;
    drdy = 1'b0;
    crdy = 1'b0;
    case (state_q)
      DATA: begin
        lb   = tx.data_bit;
        lbv  = tx.data_bit_valid;
        drdy = tx.line_bit_ready;
      end
      CTRL: begin
        lb   = tx.ctrl_bit;
        lbv  = tx.ctrl_bit_valid;
        crdy = tx.line_bit_ready;
      end
      default: begin
`ifdef TX_LINK_IDLE_FILL_EN
        lbv = run_q;
`else
        lbv = 1'b0;
`endif
      end
    endcase
  end

  assign tx.line_bit       = lb;
  assign tx.line_bit_valid = lbv;
  assign tx.data_bit_ready = drdy;
  assign tx.ctrl_bit_ready = crdy;

  assign hs       = lbv && tx.line_bit_ready;
  assign in_frame = (state_q == DATA) || (state_q == CTRL);
  // A stall only counts once the frame has started; waiting for bit 0 is not an underrun.
  assign stall    = in_frame && (bit_cnt_q != '0) && !lbv;

`ifdef TX_LINK_IDLE_FILL_EN
  assign gap_tick = hs;
`else
  assign gap_tick = 1'b1;
`endif

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      streak_q     <= '0;
      frames_q     <= '0;
      underrun_q   <= '0;
      frame_done_q <= 1'b0;
      stall_q      <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      stall_q      <= stall;
      if (stall && !stall_q && (underrun_q != 8'hFF))
        underrun_q <= underrun_q + 8'd1;
      case (state_q)
        IDLE: begin
          if (tx.ctrl_bit_valid && (!tx.data_bit_valid || (streak_q != STREAK_MAX)))
            state_q <= CTRL;
          else if (tx.data_bit_valid)
            state_q <= DATA;
        end
        DATA, CTRL: begin
          if (hs) begin
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q    <= '0;
              frame_done_q <= 1'b1;
              frames_q     <= frames_q + 16'd1;
              state_q      <= (GAP_BITS > 0) ? GAP : IDLE;
              // Ctrl streak only matters while data is actually waiting.
              if ((state_q == DATA) || !tx.data_bit_valid)
                streak_q <= '0;
              else if (streak_q != STREAK_MAX)
                streak_q <= streak_q + 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_tick) begin
            if (gap_cnt_q == GAP_LAST) begin
              gap_cnt_q <= '0;
              state_q   <= IDLE;
            end else begin
              gap_cnt_q <= gap_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_ctrl     = (state_q == CTRL);
  assign frame_done     = frame_done_q;
  assign frames_sent    = frames_q;
  assign underrun_count = underrun_q;

endmodule

// File: tb/tb_tx_link_scheduler.sv
// Scoreboard bench for tx_link_scheduler: stimulus pushes expected line bits, a negedge monitor checks them.
module tb_tx_link_scheduler;
  localparam int FB = 56;
  localparam int GB = 4;

  typedef struct packed {
    logic b;
    logic c;
  } exp_t;

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b0;
  logic        grant_ctrl, frame_done;
  logic [15:0] frames_sent;
  logic [7:0]  underrun_count;

  always #5 clk_sys = ~clk_sys;

  tx_link_scheduler_if tif ();

  tx_link_scheduler #(.FRAME_BITS(FB), .GAP_BITS(GB), .MAX_CTRL_BURST(3)) dut (
    .clk_sys        (clk_sys),
    .rst_n          (rst_n),
    .tx             (tif),
    .grant_ctrl     (grant_ctrl),
    .frame_done     (frame_done),
    .frames_sent    (frames_sent),
    .underrun_count (underrun_count)
  );

  exp_t expq[$];
  logic dq[$];
  logic cq[$];
  int   checks = 0, errors = 0, cyc = 0;
  int   bits_in_frame = 0, frames_exp = 0, done_cnt = 0, last_hs = 0;
  bit   have_prev = 0, gap_exact = 0, stall_en = 0;
  int   rdy_mode = 0, d_sent = 0, stall_ptr = 0, stall_cnt = 0;
  int   stall_pos[3] = '{30, 40, 50};
  int   stall_len[3] = '{10, 3, 2};

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [FB-1:0] dpat(input int k);
    logic [7:0] kb = k[7:0];
    return 56'hAABBCCDD_EEFF11 ^ {kb, 48'h0};
  endfunction

  function automatic logic [FB-1:0] cpat(input int k);
    logic [7:0] kb = k[7:0];
    return 56'hC35A960FF0693C ^ {kb, 48'h0};
  endfunction

  task automatic load(input bit c, input logic [FB-1:0] pat);
    for (int i = FB - 1; i >= 0; i--)
      if (c) cq.push_back(pat[i]); else dq.push_back(pat[i]);
  endtask

  task automatic expect_f(input bit c, input logic [FB-1:0] pat);
    exp_t e;
    for (int i = FB - 1; i >= 0; i--) begin
      e.b = pat[i];
      e.c = c;
      expq.push_back(e);
    end
  endtask

  task automatic clear_sb();
    dq.delete(); cq.delete(); expq.delete();
    bits_in_frame = 0; frames_exp = 0; done_cnt = 0; have_prev = 0; gap_exact = 0;
    d_sent = 0; stall_en = 0; stall_ptr = 0; stall_cnt = 0; rdy_mode = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_sb();
    repeat (2) @(posedge clk_sys);
    #1;
    chk("rst_line_valid", 32'(tif.line_bit_valid), 0);
    chk("rst_line_bit", 32'(tif.line_bit), 1);
    chk("rst_data_ready", 32'(tif.data_bit_ready), 0);
    chk("rst_ctrl_ready", 32'(tif.ctrl_bit_ready), 0);
    chk("rst_grant_ctrl", 32'(grant_ctrl), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_frames_sent", 32'(frames_sent), 0);
    chk("rst_underrun", 32'(underrun_count), 0);
    @(negedge clk_sys);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (expq.size() != 0 && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    if (expq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d bits outstanding, expected 0", expq.size());
    end
    repeat (GB + 4) @(negedge clk_sys);
  endtask

  // Data source: presents the queue head, pops on an accepted handshake, optional stall schedule.
  initial begin
    logic acc;
    tif.data_bit = 1'b0; tif.data_bit_valid = 1'b0;
    forever begin
      @(negedge clk_sys);
      acc = tif.data_bit_valid && tif.data_bit_ready;
      @(posedge clk_sys); #1;
      if (acc && dq.size() > 0) begin void'(dq.pop_front()); d_sent++; end
      if (stall_cnt == 0 && stall_en && stall_ptr < 3 && d_sent == stall_pos[stall_ptr]) begin
        stall_cnt = stall_len[stall_ptr];
        stall_ptr++;
      end
      if (stall_cnt > 0) begin
        stall_cnt--;
        tif.data_bit_valid = 1'b0;
      end else begin
        tif.data_bit_valid = (dq.size() > 0);
        tif.data_bit       = (dq.size() > 0) ? dq[0] : 1'b0;
      end
    end
  end

  initial begin
    logic acc;
    tif.ctrl_bit = 1'b0; tif.ctrl_bit_valid = 1'b0;
    forever begin
      @(negedge clk_sys);
      acc = tif.ctrl_bit_valid && tif.ctrl_bit_ready;
      @(posedge clk_sys); #1;
      if (acc && cq.size() > 0) void'(cq.pop_front());
      tif.ctrl_bit_valid = (cq.size() > 0);
      tif.ctrl_bit       = (cq.size() > 0) ? cq[0] : 1'b0;
    end
  end

  initial begin
    tif.line_bit_ready = 1'b1;
    forever begin
      @(posedge clk_sys); #1;
      tif.line_bit_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(1, 0) != 0);
    end
  end

  // Monitor: every source-bit handshake pops one expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_sys);
      if (rst_n) begin
        if (tif.line_bit_valid && tif.line_bit_ready) begin
          if (tif.data_bit_ready || tif.ctrl_bit_ready) begin
            if (expq.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_bit: got bit %0b, expected no traffic", tif.line_bit);
            end else begin
              e = expq.pop_front();
              chk("line_bit", 32'(tif.line_bit), 32'(e.b));
              chk("grant_src", 32'(grant_ctrl), 32'(e.c));
              if (bits_in_frame == 0 && have_prev && gap_exact)
                chk("gap_cycles", 32'(cyc - last_hs), GB + 2);
            end
            bits_in_frame++;
            last_hs   = cyc;
            have_prev = 1'b1;
          end else begin
`ifdef TX_LINK_IDLE_FILL_EN
            chk("idle_fill_bit", 32'(tif.line_bit), 1);
`else
            checks++; errors++;
            $display("FAIL spurious_valid: got line_bit_valid=1 with no grant, expected 0");
`endif
          end
        end
        if (grant_ctrl) chk("data_ready_in_ctrl", 32'(tif.data_bit_ready), 0);
        if (frame_done) begin
          frames_exp++;
          done_cnt++;
          chk("frames_sent", 32'(frames_sent), 32'(frames_exp));
          chk("frame_len", 32'(bits_in_frame), FB);
          bits_in_frame = 0;
        end
      end
    end
  end

  initial begin
    int n;
    do_reset();

    // Reset in the middle of a ctrl frame, then a fresh frame must start at bit 0.
    load(1, cpat(0)); expect_f(1, cpat(0));
    n = 0;
    while (bits_in_frame < 20 && n < 500) begin @(negedge clk_sys); n++; end
    chk("mid_frame_reached", 32'(bits_in_frame), 20);
    @(posedge clk_sys); #2;
    rst_n = 1'b0;
    clear_sb();
    #1;
    chk("async_rst_line_valid", 32'(tif.line_bit_valid), 0);
    chk("async_rst_ctrl_ready", 32'(tif.ctrl_bit_ready), 0);
    chk("async_rst_line_bit", 32'(tif.line_bit), 1);
    chk("async_rst_grant", 32'(grant_ctrl), 0);
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys); rst_n = 1'b1;
    load(1, cpat(1)); expect_f(1, cpat(1));
    wait_drain(500);
    chk("frames_after_reset", 32'(frames_sent), 1);

    // Data only: two back-to-back frames, exact gap between them.
    do_reset();
    gap_exact = 1'b1;
    load(0, dpat(0)); load(0, dpat(1));
    expect_f(0, dpat(0)); expect_f(0, dpat(1));
    wait_drain(1000);
    chk("data_frames_sent", 32'(frames_sent), 2);
    chk("data_done_pulses", 32'(done_cnt), 2);

    // Both sources saturated: C,C,C,D,C,C,C,D.
    do_reset();
    gap_exact = 1'b1;
    for (int k = 0; k < 6; k++) load(1, cpat(k));
    load(0, dpat(2)); load(0, dpat(3));
    for (int k = 0; k < 3; k++) expect_f(1, cpat(k));
    expect_f(0, dpat(2));
    for (int k = 3; k < 6; k++) expect_f(1, cpat(k));
    expect_f(0, dpat(3));
    wait_drain(3000);
    chk("arb_frames_sent", 32'(frames_sent), 8);
    chk("arb_done_pulses", 32'(done_cnt), 8);

    // Three stall episodes in one data frame; ctrl arriving mid-frame must wait.
    do_reset();
    gap_exact = 1'b1;
    stall_en  = 1'b1;
    load(0, dpat(4));
    expect_f(0, dpat(4)); expect_f(1, cpat(6));
    n = 0;
    while (bits_in_frame < 5 && n < 200) begin @(negedge clk_sys); n++; end
    load(1, cpat(6));
    wait_drain(1000);
    chk("underrun_count", 32'(underrun_count), 3);
    chk("underrun_frames", 32'(frames_sent), 2);

    // Pseudo-random line back-pressure during a ctrl frame.
    do_reset();
    rdy_mode = 1;
    load(1, cpat(7)); expect_f(1, cpat(7));
    wait_drain(1000);
    rdy_mode = 0;
    chk("bp_done_pulses", 32'(done_cnt), 1);

    // No sources: idle line behaviour.
    do_reset();
    repeat (20) begin
      @(negedge clk_sys);
`ifdef TX_LINK_IDLE_FILL_EN
      chk("idle_valid", 32'(tif.line_bit_valid), 1);
`else
      chk("idle_valid", 32'(tif.line_bit_valid), 0);
`endif
      chk("idle_line_bit", 32'(tif.line_bit), 1);
    end
    chk("idle_frames_sent", 32'(frames_sent), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
